// File: rtl/alu_seq.sv
// Handshaked signed ALU with a registered, sign-extended 2*WIDTH result.
// Multiply is iterative shift-add on operand magnitudes, one multiplier bit per cycle.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [2:0]         mode_i,
    input  logic [WIDTH-1:0]   op_a_i,
    input  logic [WIDTH-1:0]   op_b_i,
    input  logic               sigma_n_i,
    output logic               valid_o,
    output logic [2*WIDTH-1:0] res_o
);

    localparam int RES_W = 2 * WIDTH;
    localparam int SH_W  = $clog2(WIDTH);
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [2:0] MODE_ADD_ONE = 3'd0;
    localparam logic [2:0] MODE_SUB_ONE = 3'd1;
    localparam logic [2:0] MODE_ADD_SUB = 3'd2;
    localparam logic [2:0] MODE_MUL     = 3'd3;
    localparam logic [2:0] MODE_SHR     = 3'd5;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_MUL  = 1'b1;

    logic [0:0]              state;
    logic [RES_W-1:0]        mcand;
    logic [WIDTH-1:0]        mplier;
    logic [RES_W-1:0]        acc;
    logic                    sign;
    logic [CNT_W-1:0]        cnt;

    logic signed [RES_W-1:0] a_ext;
    logic signed [RES_W-1:0] b_ext;
    logic [SH_W-1:0]         shamt;
    logic [RES_W-1:0]        alu_res;
    logic [WIDTH-1:0]        abs_a;
    logic [WIDTH-1:0]        abs_b;
    logic [RES_W-1:0]        acc_next;
    logic [RES_W-1:0]        prod_signed;

    assign ready_o = (state == S_IDLE);

    // Widening first means no mode can overflow the result.
    always_comb begin
        a_ext   = {{WIDTH{op_a_i[WIDTH-1]}}, op_a_i};
        b_ext   = {{WIDTH{op_b_i[WIDTH-1]}}, op_b_i};
        shamt   = op_b_i[SH_W-1:0];
        alu_res = '0;
        case (mode_i)
            MODE_ADD_ONE: alu_res = a_ext + RES_W'(1);
            MODE_SUB_ONE: alu_res = a_ext - RES_W'(1);
            MODE_ADD_SUB: alu_res = sigma_n_i ? (a_ext - b_ext) : (a_ext + b_ext);
            MODE_SHR:     alu_res = a_ext >>> shamt;
            default:      alu_res = '0;
        endcase
    end

    // The most negative operand's magnitude still fits as an unsigned WIDTH-bit value.
    always_comb begin
        abs_a       = op_a_i[WIDTH-1] ? (~op_a_i + WIDTH'(1)) : op_a_i;
        abs_b       = op_b_i[WIDTH-1] ? (~op_b_i + WIDTH'(1)) : op_b_i;
        acc_next    = acc + (mplier[0] ? mcand : '0);
        prod_signed = sign ? (~acc_next + RES_W'(1)) : acc_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            res_o   <= '0;
            valid_o <= 1'b0;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            sign    <= 1'b0;
            cnt     <= '0;
        end else begin
            valid_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (valid_i) begin
                        if (mode_i == MODE_MUL) begin
                            mcand  <= {{WIDTH{1'b0}}, abs_a};
                            mplier <= abs_b;
                            sign   <= op_a_i[WIDTH-1] ^ op_b_i[WIDTH-1];
                            acc    <= '0;
                            cnt    <= CNT_W'(WIDTH);
                            state  <= S_MUL;
                        end else begin
                            res_o   <= alu_res;
                            valid_o <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - CNT_W'(1);
                    // Always runs all WIDTH bits, so latency is fixed.
                    if (cnt == CNT_W'(1)) begin
                        res_o   <= prod_signed;
                        valid_o <= 1'b1;
                        state   <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed cases with fixed expected values plus randomized
// traffic checked every cycle against a cycle-count / integer-arithmetic reference.
module tb_alu_seq;

    localparam int WIDTH = 8;
    localparam int RES_W = 2 * WIDTH;

    logic             clk;
    logic             rst;
    logic             valid_i;
    logic             ready_o;
    logic [2:0]       mode_i;
    logic [WIDTH-1:0] op_a_i;
    logic [WIDTH-1:0] op_b_i;
    logic             sigma_n_i;
    logic             valid_o;
    logic [RES_W-1:0] res_o;

    alu_seq #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .mode_i   (mode_i),
        .op_a_i   (op_a_i),
        .op_b_i   (op_b_i),
        .sigma_n_i(sigma_n_i),
        .valid_o  (valid_o),
        .res_o    (res_o)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: result of one request from integer arithmetic on signed values.
    function automatic logic [RES_W-1:0] ref_model(input logic [2:0] m, input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b, input logic s);
        longint sa;
        longint sb;
        longint r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (m)
            3'd0:    r = sa + 1;
            3'd1:    r = sa - 1;
            3'd2:    r = s ? sa - sb : sa + sb;
            3'd3:    r = sa * sb;
            3'd5:    r = sa >>> (int'(b) % WIDTH);
            default: r = 0;
        endcase
        return r[RES_W-1:0];
    endfunction

    // scoreboard: expected results with the cycle each must appear in
    logic [RES_W-1:0] exp_q[$];
    int               due_q[$];
    int               acc_q[$];
    logic [RES_W-1:0] obs_q[$];
    int               obs_cyc_q[$];
    int               cyc = 0;
    int               busy_until = 0;
    logic [RES_W-1:0] last_res = '0;
    bit               exp_valid = 1'b0;
    bit               started = 1'b0;

    always @(posedge clk) begin
        int due;
        if (rst) begin
            exp_q.delete();
            due_q.delete();
            acc_q.delete();
            busy_until = 0;
            last_res   = '0;
            started    = 1'b1;
        end else if (started && valid_i && cyc >= busy_until) begin
            exp_q.push_back(ref_model(mode_i, op_a_i, op_b_i, sigma_n_i));
            acc_q.push_back(cyc);
            if (mode_i == 3'd3) begin
                due        = cyc + WIDTH + 1;
                busy_until = due;
            end else begin
                due = cyc + 1;
            end
            due_q.push_back(due);
        end
        cyc++;
        exp_valid = 1'b0;
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            last_res = exp_q.pop_front();
            void'(due_q.pop_front());
            exp_valid = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("ready", ready_o, cyc >= busy_until);
            check("valid", valid_o, exp_valid);
            check("res", res_o, last_res);
            if (valid_o === 1'b1) begin
                obs_q.push_back(res_o);
                obs_cyc_q.push_back(cyc);
            end
        end
    end

    // driver tasks
    task automatic drive(input logic [2:0] m, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic s);
        valid_i   = 1'b1;
        mode_i    = m;
        op_a_i    = a;
        op_b_i    = b;
        sigma_n_i = s;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        valid_i = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic flush();
        obs_q.delete();
        obs_cyc_q.delete();
        acc_q.delete();
    endtask

    task automatic expect_obs(input string tag, input logic [RES_W-1:0] r, input int lat);
        if (obs_q.size() == 0 || acc_q.size() == 0) begin
            check({tag, "_present"}, 0, 1);
        end else begin
            check(tag, obs_q.pop_front(), r);
            check({tag, "_lat"}, obs_cyc_q.pop_front() - acc_q.pop_front(), lat);
        end
    endtask

    initial begin
        logic [2:0]       rm;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        rst       = 1'b1;
        valid_i   = 1'b0;
        mode_i    = '0;
        op_a_i    = '0;
        op_b_i    = '0;
        sigma_n_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_res", res_o, 0);
        check("rst_valid", valid_o, 0);
        check("rst_ready", ready_o, 1);
        flush();

        // back-to-back single-cycle ops
        drive(3'd0, 8'd127, 8'd0, 1'b0);
        drive(3'd1, 8'h80, 8'd0, 1'b0);
        drive(3'd2, 8'h80, 8'd127, 1'b1);
        drive(3'd2, 8'd100, 8'd100, 1'b0);
        idle(2);
        expect_obs("add_one", 16'h0080, 1);
        expect_obs("sub_one", 16'hFF7F, 1);
        expect_obs("add_sub_n", 16'hFF01, 1);
        expect_obs("add_sub_p", 16'd200, 1);

        // multiplies
        drive(3'd3, 8'h80, 8'h80, 1'b0);
        idle(10);
        expect_obs("mul_nn", 16'd16384, WIDTH + 1);
        drive(3'd3, 8'h80, 8'd127, 1'b0);
        idle(10);
        expect_obs("mul_np", 16'hC080, WIDTH + 1);
        drive(3'd3, 8'd0, 8'hFB, 1'b0);
        idle(10);
        expect_obs("mul_zero", 16'd0, WIDTH + 1);

        // request held high during a multiply is taken once ready returns
        drive(3'd3, 8'd7, 8'hFD, 1'b0);
        repeat (WIDTH + 1) drive(3'd0, 8'd16, 8'd0, 1'b0);
        idle(3);
        expect_obs("mul_held", 16'hFFEB, WIDTH + 1);
        expect_obs("held_op", 16'd17, 1);
        check("held_single", obs_q.size(), 0);

        // shifts and idle-like modes
        drive(3'd5, 8'h80, 8'd3, 1'b0);
        drive(3'd5, 8'd64, 8'd7, 1'b0);
        drive(3'd5, 8'hFF, 8'd5, 1'b0);
        drive(3'd4, 8'd9, 8'd9, 1'b0);
        drive(3'd6, 8'd9, 8'd9, 1'b1);
        drive(3'd7, 8'd9, 8'd9, 1'b0);
        idle(2);
        expect_obs("shr_neg", 16'hFFF0, 1);
        expect_obs("shr_pos", 16'h0000, 1);
        expect_obs("shr_m1", 16'hFFFF, 1);
        expect_obs("mode4", 16'h0000, 1);
        expect_obs("mode6", 16'h0000, 1);
        expect_obs("mode7", 16'h0000, 1);

        // reset aborts a multiply
        drive(3'd3, 8'h55, 8'h33, 1'b0);
        idle(3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle(12);
        check("abort_no_result", obs_q.size(), 0);
        check("abort_res", res_o, 0);
        check("abort_ready", ready_o, 1);
        flush();
        drive(3'd0, 8'd5, 8'd0, 1'b0);
        idle(2);
        expect_obs("post_rst_add", 16'd6, 1);

        // randomized traffic, checked every cycle by the reference
        for (int i = 0; i < 600; i++) begin
            rm = 3'($urandom_range(0, 7));
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rst       = ($urandom_range(0, 199) == 0);
            valid_i   = ($urandom_range(0, 3) != 0);
            mode_i    = rm;
            op_a_i    = ra;
            op_b_i    = rb;
            sigma_n_i = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        rst = 1'b0;
        idle(WIDTH + 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, handshaked successor of the combinational approximation ALU. It executes one operation per accepted request on signed WIDTH-bit operands and returns a registered, sign-extended 2*WIDTH result with a one-cycle valid pulse. Multiply is iterative (shift-add, one bit per cycle), which frees the datapath from a full array multiplier. An arithmetic right shift is added for iterative approximation loops. The block sits between the approximation controller FSM and its operand registers.

Parameters:
WIDTH, 8, operand width in bits; legal range 4..32; result width RES_W = 2*WIDTH (derived localparam)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
valid_i  input  1  request valid
ready_o  output  1  block can accept a request this cycle
mode_i  input  3  operation code, sampled on accept
op_a_i  input  WIDTH  signed operand A, sampled on accept
op_b_i  input  WIDTH  signed operand B / shift amount, sampled on accept
sigma_n_i  input  1  ADD_SUB direction (1: A-B, 0: A+B), sampled on accept
valid_o  output  1  one-cycle pulse, res_o updated this cycle
res_o  output  RES_W  signed result, held until next result

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE, res_o=0, valid_o=0, ready_o=1 in the following cycle. Reset aborts any multiply in progress; the partial result is discarded and never emitted.
- Accept: valid_i & ready_o at a rising edge. valid_i while ready_o=0 is ignored and is not queued.
- Mode codes:
  - 0 ADD_ONE: A+1
  - 1 SUB_ONE: A-1
  - 2 ADD_SUB: sigma_n ? A-B : A+B
  - 3 MULTIPLY: A*B
  - 4 IDLE: result 0
  - 5 SHR: A >>> B[clog2(WIDTH)-1:0], arithmetic, B's low bits unsigned
  - 6, 7: treated as IDLE, result 0
- Arithmetic: operands are sign-extended to RES_W before computing, so no overflow is possible and there is no wrap in any mode.
- States: IDLE and MUL.
- IDLE:
  - ready_o=1.
  - On accept of a non-multiply mode: res_o is written at that edge and valid_o=1 in the next cycle. Latency is 1 cycle and ready_o stays 1, so back-to-back accepts every cycle are legal.
  - On accept of MULTIPLY: load |A| and |B| as WIDTH-bit unsigned magnitudes (|-2^(WIDTH-1)| = 2^(WIDTH-1) is representable), latch sign = A[msb]^B[msb], clear the accumulator, set the iteration counter to WIDTH, and go to MUL.
- MUL:
  - ready_o=0 and valid_o=0.
  - Each edge adds the shifted multiplicand if the current multiplier bit is 1, then decrements the counter.
  - On the edge processing the last bit: write res_o = sign ? -product : product and return to IDLE.
  - If the multiply is accepted at the edge ending cycle T, ready_o=0 for cycles T+1..T+WIDTH, and valid_o=1 with ready_o=1 in cycle T+WIDTH+1.
- A zero operand gives no early termination; latency is always WIDTH+1.
- valid_o is 1 for exactly one cycle per accepted request. res_o keeps its value between results, including while in MUL.
- Reset has priority over accept on the same edge.

Test Plan:
- Reset, then hold rst=1 for 2 cycles -> res_o=0, valid_o=0, ready_o=1 in the first cycle after rst falls.
- WIDTH=8, back-to-back accepts on consecutive cycles:
  - ADD_ONE A=127 -> res_o=128 (16'h0080)
  - SUB_ONE A=-128 -> res_o=-129 (16'hFF7F)
  - ADD_SUB sigma_n=1, A=-128, B=127 -> -255
  - ADD_SUB sigma_n=0, A=100, B=100 -> 200
  - Required: each result has valid_o 1 cycle after its accept, and ready_o never drops.
- MULTIPLY, accepted at cycle T:
  - A=-128, B=-128 -> res_o=16384 at T+9
  - A=-128, B=127 -> -16256
  - A=0, B=-5 -> 0 with latency still 9
  - Required: ready_o=0 for T+1..T+8.
- MULTIPLY A=7, B=-3, with valid_i held high and a different op applied during MUL -> only one result (-21) is emitted, and the held request is accepted at T+9 when ready_o returns.
- SHR A=-128, B=3 -> -16. SHR A=64, B=7 -> 0. SHR A=-1, B=5 -> -1. Modes 4, 6 and 7 -> res_o=0 with a valid_o pulse.
- Assert rst at cycle T+4 of a multiply -> no valid_o pulse, res_o=0, ready_o=1 after reset. A new ADD_ONE A=5 then returns 6 with 1-cycle latency.
